axi_lite_reg_slave: RTL
=======================

Name: axi_lite_reg_slave

Overview:
AXI4-Lite slave register bank that sits directly downstream of the AHB-to-AXI bridge, consuming its AR/AW/W channels and returning R/B responses. It holds NUM_REGS 32-bit control registers, exposed as a flat output bus to the image-recognition datapath. The top word is a read-only status word fed from hardware. It gives the CPU side a clean, fully handshaked register window.

Parameters:
ADDR_W, 32, address width of awaddr/araddr
NUM_REGS, 16, number of 32-bit words in the window, including the status word; minimum 2
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to NUM_REGS*4

Ports:
clk  in  1  single clock, all logic rising-edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
awaddr  in  ADDR_W  write address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  32  write data
wstrb  in  4  byte strobes, bit n enables wdata[8n+7:8n]
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response
bvalid  out  1  write response valid
bready  in  1  write response ready
araddr  in  ADDR_W  read address
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  32  read data
rresp  out  2  read response
rvalid  out  1  read data valid
rready  in  1  read data ready
ctrl_regs  out  32*(NUM_REGS-1)  control registers; word i occupies bits [32i+31:32i]
sts_in  in  32  status word, read at index NUM_REGS-1

Behaviour:
- Reset (reset=0, async): all ctrl registers = 0; awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=0, rdata=0; hold flags cleared. Deassertion takes effect at the next clk edge; ready signals rise on the first cycle after release.
- Decode: off = addr - BASE_ADDR; idx = off[..:2]; addr[1:0] ignored. In range iff addr >= BASE_ADDR and off < NUM_REGS*4.
- Write path:
  - AW and W are accepted independently into one-entry holds (aw_held/awaddr_q, w_held/wdata_q/wstrb_q).
  - awready = !aw_held & !bvalid; wready = !w_held & !bvalid.
- Write FSM, W_IDLE -> W_RESP:
  - The transition occurs on the edge where both AW and W are available, held or handshaking that cycle, including same-cycle arrival.
  - On that edge, if idx < NUM_REGS-1 and in range: per-byte merge of wdata under wstrb into ctrl word idx; bresp = OKAY (2'b00).
  - Out of range, or idx = NUM_REGS-1 (read-only): no register changes; bresp = SLVERR (2'b10).
  - bvalid=1 and holds clear on the same edge.
- W_RESP: bvalid and bresp stay stable until bready=1, then the FSM returns to W_IDLE. No new AW/W is accepted while bvalid=1.
- wstrb=0 with an in-range address: no change, OKAY.
- Read FSM, R_IDLE -> R_VALID:
  - arready = !rvalid.
  - On the AR handshake, next edge: rvalid=1, rdata = ctrl word idx, or sts_in for the top index (sampled that edge), or 0 if out of range.
  - rresp = OKAY, or SLVERR if out of range. Read latency is 1 cycle from the handshake.
- R_VALID: rdata/rresp held stable until rready=1, then R_IDLE. arready reasserts the cycle after the R handshake, so back-to-back reads run at one per 2 cycles.
- Simultaneous events:
  - Read and write to the same word committing on the same edge: the read returns the pre-write value.
  - Read and write channels are fully independent; neither blocks the other.
- Reset mid-transaction: outstanding holds and responses are discarded; no partial register update.
- ctrl_regs are driven directly from flops, so an update is visible one cycle after the commit edge.

Decomposition:
- Shared package axi_lite_pkg: RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11; DATA_W=32; STRB_W=4. The package is reused by the bridge.
- One natural sub-module, axi_lite_strb_merge: combinational merge of old word, wdata and wstrb into the new word.
- The FSMs stay in the top module.

Test Plan:
- Reset release, then AW(0x04) and W(0xDEADBEEF, strb 4'hF) in the same cycle, bready=1 -> bvalid 1 cycle later with bresp=00; ctrl word1 = 0xDEADBEEF; a read of 0x04 returns 0xDEADBEEF with rresp=00 one cycle after arready.
- W(0x000000AA, strb 4'b0001) 3 cycles before AW(0x04) -> wready drops after the W handshake; the commit happens on the AW edge; word1 = 0xDEADBEAA.
- Write 0x3C (status index, NUM_REGS=16), then read 0x3C with sts_in=0x12345678 -> bresp=10 with no change; rdata=0x12345678, rresp=00.
- Read 0x40 and write 0x80 -> rresp=10, rdata=0; bresp=10; all ctrl_regs unchanged.
- Hold bready=0 and rready=0 for 5 cycles -> bvalid/bresp and rvalid/rdata stay stable; awready=wready=arready=0 throughout; all recover after the ready goes high.
- Assert reset low while a W is held and bvalid=1 -> all outputs 0 immediately; after release a fresh write works and the earlier held W is never committed.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: data/strobe widths and response codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_lite_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

endpackage

// File: rtl/axi_lite_strb_merge.sv
// Byte-strobe merge: each byte lane takes wdata when its strobe is set, else keeps the old word.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module axi_lite_strb_merge
  import axi_lite_pkg::*;
(
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  output logic [DATA_W-1:0] new_word
);

  // Select each byte lane independently from old or new data.
  always_comb begin
    new_word = old_word;
    for (int b = 0; b < STRB_W; b++) begin
      if (wstrb[b]) begin
        new_word[8*b +: 8] = wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register window: NUM_REGS-1 read/write control words plus a read-only status word on top.
// Latency: B one cycle after AW and W are both present; R one cycle after the AR handshake.
// Backpressure: AW/W/AR stall while their own response is pending; B and R hold until bready/rready.
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                NUM_REGS  = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          awaddr,
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [STRB_W-1:0]          wstrb,
  input  logic                       wvalid,
  output logic                       wready,
  output logic [1:0]                 bresp,
  output logic                       bvalid,
  input  logic                       bready,
  input  logic [ADDR_W-1:0]          araddr,
  input  logic                       arvalid,
  output logic                       arready,
  output logic [DATA_W-1:0]          rdata,
  output logic [1:0]                 rresp,
  output logic                       rvalid,
  input  logic                       rready,
  output logic [32*(NUM_REGS-1)-1:0] ctrl_regs,
  input  logic [DATA_W-1:0]          sts_in
);

  localparam int                IDX_W     = $clog2(NUM_REGS);
  localparam int                CTRL_N    = NUM_REGS - 1;
  localparam logic [ADDR_W-1:0] WIN_BYTES = ADDR_W'(NUM_REGS * 4);
  localparam logic [IDX_W-1:0]  STS_IDX   = IDX_W'(NUM_REGS - 1);

  typedef enum logic {W_IDLE, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_VALID} rd_state_e;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } dec_t;

  // Byte address to word index; the low two address bits do not select anything.
  function automatic dec_t decode(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    dec_t              d;
    off   = addr - BASE_ADDR;
    d.hit = (addr >= BASE_ADDR) && (off < WIN_BYTES);
    d.idx = off[IDX_W+1:2];
    return d;
  endfunction

  logic                      rdy_en;
  logic [CTRL_N*DATA_W-1:0]  ctrl_q;

  wr_state_e                 wr_state, wr_state_nxt;
  logic                      wr_commit;
  logic                      aw_held, w_held;
  logic [ADDR_W-1:0]         awaddr_q;
  logic [DATA_W-1:0]         wdata_q;
  logic [STRB_W-1:0]         wstrb_q;
  logic                      aw_fire, w_fire, aw_avail, w_avail;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic [STRB_W-1:0]         wr_strb;
  dec_t                      wr_dec;
  logic                      wr_ok;
  logic [DATA_W-1:0]         wr_old, wr_new;
  logic [1:0]                bresp_q;

  rd_state_e                 rd_state, rd_state_nxt;
  logic                      ar_fire;
  dec_t                      rd_dec;
  logic [DATA_W-1:0]         rd_word;
  logic [DATA_W-1:0]         rdata_q;
  logic [1:0]                rresp_q;

  // Ready outputs stay low through reset and rise one edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  assign bvalid  = (wr_state == W_RESP);
  assign rvalid  = (rd_state == R_VALID);
  assign awready = rdy_en & ~aw_held & ~bvalid;
  assign wready  = rdy_en & ~w_held & ~bvalid;
  assign arready = rdy_en & ~rvalid;
  assign bresp   = bresp_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q;
  assign ctrl_regs = ctrl_q;

  assign aw_fire  = awvalid & awready;
  assign w_fire   = wvalid & wready;
  assign aw_avail = aw_held | aw_fire;
  assign w_avail  = w_held | w_fire;

  // A held beat takes priority; otherwise the beat handshaking this cycle is used directly.
  assign wr_addr = aw_held ? awaddr_q : awaddr;
  assign wr_data = w_held  ? wdata_q  : wdata;
  assign wr_strb = w_held  ? wstrb_q  : wstrb;
  assign wr_dec  = decode(wr_addr);
  assign wr_ok   = wr_dec.hit && (wr_dec.idx != STS_IDX);

  // Capture AW and W independently until the other half arrives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      if (wr_commit) begin
        aw_held <= 1'b0;
      end else if (aw_fire) begin
        aw_held  <= 1'b1;
        awaddr_q <= awaddr;
      end
      if (wr_commit) begin
        w_held <= 1'b0;
      end else if (w_fire) begin
        w_held  <= 1'b1;
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
    end
  end

  // Write FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wr_state <= W_IDLE;
    else        wr_state <= wr_state_nxt;
  end

  // Write FSM: commit once both address and data are present, then hold B until accepted.
  always_comb begin
    wr_state_nxt = wr_state;
    wr_commit    = 1'b0;
    case (wr_state)
      W_IDLE: begin
        if (aw_avail && w_avail) begin
          wr_commit    = 1'b1;
          wr_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (bready) wr_state_nxt = W_IDLE;
      end
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  // Current contents of the word being written, for the byte merge.
  always_comb begin
    wr_old = '0;
    for (int i = 0; i < CTRL_N; i++) begin
      if (wr_dec.idx == IDX_W'(i)) wr_old = ctrl_q[i*DATA_W +: DATA_W];
    end
  end

  axi_lite_strb_merge u_merge (
    .old_word (wr_old),
    .wdata    (wr_data),
    .wstrb    (wr_strb),
    .new_word (wr_new)
  );

  // Control word update and write response on the commit edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q  <= '0;
      bresp_q <= '0;
    end else if (wr_commit) begin
      bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      for (int i = 0; i < CTRL_N; i++) begin
        if (wr_ok && (wr_dec.idx == IDX_W'(i))) ctrl_q[i*DATA_W +: DATA_W] <= wr_new;
      end
    end
  end

  assign ar_fire = arvalid & arready;
  assign rd_dec  = decode(araddr);

  // Read source: control word, live status word at the top index, or zero outside the window.
  always_comb begin
    rd_word = '0;
    if (rd_dec.hit) begin
      if (rd_dec.idx == STS_IDX) begin
        rd_word = sts_in;
      end else begin
        for (int i = 0; i < CTRL_N; i++) begin
          if (rd_dec.idx == IDX_W'(i)) rd_word = ctrl_q[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_state <= R_IDLE;
    else        rd_state <= rd_state_nxt;
  end

  // Read FSM: one-cycle data after AR, held until the R handshake.
  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_fire) rd_state_nxt = R_VALID;
      R_VALID: if (rready)  rd_state_nxt = R_IDLE;
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  // Capture read data/response on the AR handshake; a same-edge write is not yet visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
      rresp_q <= '0;
    end else if (ar_fire) begin
      rdata_q <= rd_word;
      rresp_q <= rd_dec.hit ? RESP_OKAY : RESP_SLVERR;
    end
  end

endmodule
